sequence_memory: RTL and testbench

Generates and stores the random colour sequence for one Simon Says game. It feeds `led_to_glow` to the blinker, which drives the read address through its `count` output. A second read port serves the player-input checker. On each new game, a free-running 16-bit LFSR fills a 16-entry, 2-bit-wide memory, one entry per clock, and then `ready` is raised for the game FSM.

---
 rtl/sequence_memory_if.sv | 23 ++
 rtl/sequence_memory.sv | 150 +++++++++++++++
 tb/tb_sequence_memory.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sequence_memory_if.sv
// Purpose: bundles the game-side request, read addresses and read data of sequence_memory.
// Latency: wiring only; read data arrives one clock after its address.
// Backpressure: none; new_game is a level request and both read ports are always open.
interface sequence_memory_if;
   logic       new_game;
   logic [3:0] count;
   logic [3:0] chk_addr;
   logic [1:0] led_to_glow;
   logic [1:0] chk_data;
   logic       ready;

   // Game FSM, blinker and checker side.
   modport master (
      output new_game, count, chk_addr,
      input  led_to_glow, chk_data, ready
   );

   // Sequence memory side.
   modport slave (
      input  new_game, count, chk_addr,
      output led_to_glow, chk_data, ready
   );
endinterface

// File: rtl/sequence_memory.sv
// Purpose: LFSR-filled 16 x 2-bit colour sequence with two independent read ports.
// Latency: fill takes 16 clocks after new_game; each read port returns data 1 clock after its address.
// Backpressure: new_game is ignored during FILL; outputs read 2'b00 until the sequence is complete.
// Optional feature: define SEQ_NO_REPEAT_EN to bump any entry equal to its predecessor by one (mod 4).
module sequence_memory #(
   parameter int          DEPTH = 16,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   sequence_memory_if.slave  bus
);

   // An all-zero seed would lock a Galois LFSR at zero forever.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] lfsr;
   logic [3:0]  fill_idx;
   logic        wr_en;
   logic        fill_last;
   logic [1:0]  wr_data;
   logic [1:0]  led_raw;
   logic [1:0]  chk_raw;
   logic [1:0]  led_q;
   logic [1:0]  chk_q;
   logic        ready_q;
   logic [1:0]  mem [DEPTH];

   // Free-running LFSR; the player's timing of new_game is the entropy source.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr <= SEED_EFF;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; a new game can only start from IDLE or READY.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (bus.new_game) state_nxt = S_FILL;
         S_FILL:  if (fill_last)    state_nxt = S_READY;
         S_READY: if (bus.new_game) state_nxt = S_FILL;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: write strobe during FILL and detection of the final index.
   always_comb begin
      wr_en     = 1'b0;
      fill_last = 1'b0;
      if (state == S_FILL) begin
         wr_en     = 1'b1;
         fill_last = (fill_idx == 4'd15);
      end
   end

   // Fill index counts only while filling, so it is zero on every entry to FILL.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fill_idx <= 4'd0;
      end else if (state == S_FILL) begin
         fill_idx <= fill_idx + 4'd1;
      end else begin
         fill_idx <= 4'd0;
      end
   end

`ifdef SEQ_NO_REPEAT_EN
   logic [1:0] prev_entry;

   // Stored colour: bump the raw LFSR colour when it would repeat the previous one.
   always_comb begin
      wr_data = lfsr[1:0];
      if (lfsr[1:0] == prev_entry) begin
         wr_data = lfsr[1:0] + 2'd1;
      end
   end

   // Last colour written; survives between fills so entry 0 is checked against entry 15.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_entry <= 2'b00;
      end else if (wr_en) begin
         prev_entry <= wr_data;
      end
   end
`else
   // Stored colour is the raw LFSR colour; repeats are allowed.
   always_comb begin
      wr_data = lfsr[1:0];
   end
`endif

   // Sequence storage; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem[fill_idx] <= wr_data;
      end
   end

   // Read muxes; forward the final fill write so the first READY cycle is never stale.
   always_comb begin
      led_raw = mem[bus.count];
      chk_raw = mem[bus.chk_addr];
      if (wr_en && (bus.count == fill_idx)) begin
         led_raw = wr_data;
      end
      if (wr_en && (bus.chk_addr == fill_idx)) begin
         chk_raw = wr_data;
      end
   end

   // Registered outputs, gated to zero whenever the next registered state is not READY.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_q <= 1'b0;
         led_q   <= 2'b00;
         chk_q   <= 2'b00;
      end else begin
         ready_q <= (state_nxt == S_READY);
         led_q   <= (state_nxt == S_READY) ? led_raw : 2'b00;
         chk_q   <= (state_nxt == S_READY) ? chk_raw : 2'b00;
      end
   end

   assign bus.ready       = ready_q;
   assign bus.led_to_glow = led_q;
   assign bus.chk_data    = chk_q;

endmodule

// File: tb/tb_sequence_memory.sv
// Purpose: self-checking bench for sequence_memory with a scoreboard of expected read data.
// Latency: expects ready 16 clocks after new_game and read data 1 clock after the address.
// Backpressure: exercises new_game during FILL and reset mid-fill.
module tb_sequence_memory;

   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   sequence_memory_if sif ();

   sequence_memory #(
      .DEPTH (16),
      .SEED  (16'h0001)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] m_lfsr;
   logic [1:0]  m_prev;
   logic [1:0]  exp_mem [16];
   logic [1:0]  got_seq [16];
   logic [1:0]  old_seq [16];
   logic [1:0]  q_led [$];
   logic [1:0]  q_chk [$];
   logic [3:0]  q_adr [$];

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Reference LFSR running in lockstep with the DUT.
   always @(posedge clk) begin
      m_lfsr <= !reset ? 16'h0001 : lfsr_step(m_lfsr);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Compare the oldest outstanding read against the scoreboard.
   task automatic pop_cmp();
      logic [3:0] a;
      if (q_led.size() > 0) begin
         a = q_adr.pop_front();
         got_seq[a] = sif.led_to_glow;
         check("led_to_glow", sif.led_to_glow, q_led.pop_front());
         check("chk_data", sif.chk_data, q_chk.pop_front());
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      pop_cmp();
      sif.count    = a;
      sif.chk_addr = b;
      q_adr.push_back(a);
      q_led.push_back(exp_mem[a]);
      q_chk.push_back(exp_mem[b]);
   endtask

   task automatic rd_flush();
      @(negedge clk);
      pop_cmp();
   endtask

   task automatic sweep();
      for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a));
      rd_flush();
   endtask

   // Start a game; optionally pulse new_game or assert reset at a given fill index.
   task automatic start_game(input int pulse_at, input int reset_at);
      logic [15:0] l;
      logic [1:0]  pv;
      logic [1:0]  e;
      logic [1:0]  nm [16];
      int          lat;
      bit          done;
      @(negedge clk);
      l  = m_lfsr;
      pv = m_prev;
      for (int k = 0; k < 16; k++) begin
         l = lfsr_step(l);
         e = l[1:0];
`ifdef SEQ_NO_REPEAT_EN
         if (e == pv) e = e + 2'd1;
         pv = e;
`endif
         nm[k] = e;
      end
      sif.new_game = 1'b1;
      lat  = -1;
      done = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            sif.new_game = 1'b0;
            check("ready_drop", sif.ready, 0);
            check("led_zero_fill", sif.led_to_glow, 0);
            check("chk_zero_fill", sif.chk_data, 0);
         end
         if (i == pulse_at + 1) sif.new_game = 1'b1;
         if (i == pulse_at + 2) sif.new_game = 1'b0;
         if (i == reset_at + 1) begin
            reset = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset  = 1'b1;
            m_prev = 2'b00;
            repeat (20) @(negedge clk);
            check("ready_after_reset", sif.ready, 0);
            done = 1'b0;
            break;
         end
         if (sif.ready) begin
            lat = i - 1;
            break;
         end
      end
      if (done) begin
         check("ready_latency", lat, 16);
         exp_mem = nm;
         m_prev  = pv;
      end
   endtask

   initial begin
      int         d;
      int         reps;
      bit         have_last;
      logic [1:0] last;

      reset        = 1'b0;
      sif.new_game = 1'b0;
      sif.count    = 4'd0;
      sif.chk_addr = 4'd0;
      m_prev       = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", sif.ready, 0);
      check("rst_led", sif.led_to_glow, 0);
      check("rst_chk", sif.chk_data, 0);

      // Fill and read back.
      start_game(-1, -1);
      sweep();

      // Independent and identical addresses.
      rd(4'd3, 4'd12);
      rd(4'd7, 4'd7);
      rd_flush();
      old_seq = got_seq;

      // New game from READY gives a different sequence.
      start_game(-1, -1);
      sweep();
      d = 0;
      for (int k = 0; k < 16; k++) if (got_seq[k] != old_seq[k]) d++;
      check("seq_differs", int'(d > 0), 1);

      // new_game during FILL is ignored.
      start_game(5, -1);
      sweep();

      // Reset mid-fill, then a full fill.
      start_game(-1, 8);
      start_game(-1, -1);
      sweep();

      // Adjacent-repeat survey across many fills.
      reps      = 0;
      have_last = 1'b0;
      last      = 2'b00;
      for (int g = 0; g < 100; g++) begin
         start_game(-1, -1);
         sweep();
         if (have_last && (got_seq[0] == last)) reps++;
         for (int k = 1; k < 16; k++) if (got_seq[k] == got_seq[k-1]) reps++;
         last      = got_seq[15];
         have_last = 1'b1;
      end
`ifdef SEQ_NO_REPEAT_EN
      check("no_adjacent_repeat", reps, 0);
`else
      check("repeat_observed", int'(reps > 0), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
